// File: rtl/sdram_test_master.sv
// Write-then-read traffic generator for the host side of the SDRAM controller.
// Writes a pattern to 0..LAST_ADDR, reads it back, counts mismatches/timeouts.
module sdram_test_master #(
  parameter logic [22:0] LAST_ADDR = 23'h7FFFFF,
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        sys_clk,
  input  logic        sys_reset,
  input  logic        start,
  input  logic [1:0]  pattern_sel,
  output logic [22:0] sys_addr,
  output logic [1:0]  sys_cmd,
  output logic [15:0] sys_data_in,
  input  logic        sys_busy,
  input  logic [15:0] sys_data_out,
  input  logic        sys_data_valid,
  output logic        running,
  output logic        done,
  output logic        fail,
  output logic [15:0] err_count,
  output logic [22:0] first_err_addr
);

  localparam int unsigned AW = 23;
  localparam int unsigned DW = 16;
  localparam int unsigned TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_WR  = 2'b01;
  localparam logic [1:0] CMD_RD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WR_ISSUE, ST_RD_ISSUE, ST_RD_WAIT, ST_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   lfsr_q, lfsr_d;
  logic [1:0]      mode_q, mode_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [1:0]      cmd_q, cmd_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   din_q, din_d;
  logic            running_q, running_d;
  logic            done_q, done_d;
  logic            fail_q, fail_d;
  logic [DW-1:0]   err_q, err_d;
  logic [AW-1:0]   first_q, first_d;

  logic            accept;
  logic            last;
  logic [AW-1:0]   cnt_inc;
  logic [DW-1:0]   lfsr_nx;
  logic [DW-1:0]   err_inc;
  logic            resolved;
  logic            is_err;

  // Pattern value for an address; mode 3 takes the current LFSR state.
  function automatic logic [DW-1:0] pat(input logic [1:0] m, input logic [AW-1:0] a,
                                        input logic [DW-1:0] l);
    case (m)
      2'd0:    pat = a[15:0];
      2'd1:    pat = ~a[15:0];
      2'd2:    pat = a[15:0] ^ {a[22:16], 9'h000};
      default: pat = l;
    endcase
  endfunction

  // Shared helper terms for the next-state logic.
  always_comb begin
    accept   = (cmd_q != CMD_NOP) && !sys_busy;
    last     = (cnt_q == LAST_ADDR);
    cnt_inc  = cnt_q + AW'(1);
    lfsr_nx  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    err_inc  = (err_q == 16'hFFFF) ? err_q : err_q + DW'(1);
    resolved = sys_data_valid || (tmo_q == TW'(TIMEOUT));
    is_err   = sys_data_valid ? (sys_data_out != pat(mode_q, cnt_q, lfsr_q)) : 1'b1;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lfsr_d    = lfsr_q;
    mode_d    = mode_q;
    tmo_d     = tmo_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    din_d     = din_q;
    running_d = running_q;
    done_d    = done_q;
    fail_d    = fail_q;
    err_d     = err_q;
    first_d   = first_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_WR_ISSUE;
          cnt_d     = '0;
          err_d     = '0;
          first_d   = '0;
          fail_d    = 1'b0;
          done_d    = 1'b0;
          running_d = 1'b1;
          mode_d    = pattern_sel;
          lfsr_d    = LFSR_SEED;
          cmd_d     = CMD_WR;
          addr_d    = '0;
          din_d     = pat(pattern_sel, '0, LFSR_SEED);
        end
      end
      ST_WR_ISSUE: begin
        if (accept) begin
          if (last) begin
            state_d = ST_RD_ISSUE;
            cnt_d   = '0;
            lfsr_d  = LFSR_SEED;
            cmd_d   = CMD_RD;
            addr_d  = '0;
          end else begin
            cnt_d   = cnt_inc;
            lfsr_d  = lfsr_nx;
            cmd_d   = CMD_WR;
            addr_d  = cnt_inc;
            din_d   = pat(mode_q, cnt_inc, lfsr_nx);
          end
        end
      end
      ST_RD_ISSUE: begin
        if (accept) begin
          state_d = ST_RD_WAIT;
          cmd_d   = CMD_NOP;
          tmo_d   = '0;
        end
      end
      ST_RD_WAIT: begin
        if (resolved) begin
          // Step even on timeout so later addresses stay aligned with the write pass.
          lfsr_d = lfsr_nx;
          if (is_err) begin
            err_d = err_inc;
            if (err_q == '0) first_d = cnt_q;
          end
          if (last) begin
            state_d   = ST_DONE;
            done_d    = 1'b1;
            running_d = 1'b0;
            fail_d    = is_err || (err_q != '0);
          end else begin
            state_d = ST_RD_ISSUE;
            cnt_d   = cnt_inc;
            cmd_d   = CMD_RD;
            addr_d  = cnt_inc;
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      lfsr_q    <= LFSR_SEED;
      mode_q    <= '0;
      tmo_q     <= '0;
      cmd_q     <= CMD_NOP;
      addr_q    <= '0;
      din_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      err_q     <= '0;
      first_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      mode_q    <= mode_d;
      tmo_q     <= tmo_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      running_q <= running_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
      err_q     <= err_d;
      first_q   <= first_d;
    end
  end

  assign sys_cmd        = cmd_q;
  assign sys_addr       = addr_q;
  assign sys_data_in    = din_q;
  assign running        = running_q;
  assign done           = done_q;
  assign fail           = fail_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;

endmodule

// File: tb/tb_sdram_test_master.sv
// Randomized bench for sdram_test_master with an ideal latency-3 memory model.
module tb_sdram_test_master;

  localparam logic [22:0] LAST = 23'd15;
  localparam int N = 16;
  localparam int L = 3;

  logic        sys_clk = 1'b0;
  logic        sys_reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [22:0] sys_addr;
  logic [1:0]  sys_cmd;
  logic [15:0] sys_data_in;
  logic        sys_busy = 1'b0;
  logic [15:0] sys_data_out = 16'h0;
  logic        sys_data_valid = 1'b0;
  logic        running, done, fail;
  logic [15:0] err_count;
  logic [22:0] first_err_addr;

  sdram_test_master #(.LAST_ADDR(LAST), .TIMEOUT(8), .LFSR_SEED(16'hACE1)) dut (
    .sys_clk(sys_clk), .sys_reset(sys_reset), .start(start), .pattern_sel(pattern_sel),
    .sys_addr(sys_addr), .sys_cmd(sys_cmd), .sys_data_in(sys_data_in),
    .sys_busy(sys_busy), .sys_data_out(sys_data_out), .sys_data_valid(sys_data_valid),
    .running(running), .done(done), .fail(fail), .err_count(err_count),
    .first_err_addr(first_err_addr)
  );

  always #5 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;

  task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected data for address a: direct arithmetic, LFSR walked a steps from the seed.
  function automatic logic [15:0] ref_pat(input int m, input int a);
    logic [22:0] aa;
    logic [15:0] v;
    aa = 23'(a);
    case (m)
      0: return aa[15:0];
      1: return ~aa[15:0];
      2: return aa[15:0] ^ {aa[22:16], 9'h000};
      default: begin
        v = 16'hACE1;
        for (int k = 0; k < a; k++) v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
        return v;
      end
    endcase
  endfunction

  // Scenario configuration, written by the stimulus process.
  int cfg_mode = 0;
  int cfg_busy_pct = 0;
  int cfg_stuck = -1;
  int cfg_drop = -1;

  // Memory model / monitor state.
  logic [15:0] mem [N];
  logic [15:0] wr_cap [3];
  int wr_idx = 0, rd_idx = 0, rd_cnt = 0, rd_addr = 0;
  int cyc = 0, wr_first = 0, wr_last = 0;
  logic        prev_busy = 1'b0;
  logic [40:0] prev_cmd_bus = '0;

  // Memory model: observe accepts mid-cycle, drive busy/response just after the edge.
  always begin
    @(negedge sys_clk);
    cyc++;
    if (sys_reset) begin
      rd_cnt = 0; wr_idx = 0; rd_idx = 0; prev_busy = 1'b0;
    end else begin
      if (start) begin wr_idx = 0; rd_idx = 0; end
      if (prev_busy && prev_cmd_bus[40:39] != 2'b00)
        check_eq("hold", 48'({sys_cmd, sys_addr, sys_data_in}), 48'(prev_cmd_bus));
      if (sys_cmd == 2'b01 && !sys_busy) begin
        check_eq("wr_addr", 48'(sys_addr), 48'(wr_idx));
        check_eq("wr_data", 48'(sys_data_in), 48'(ref_pat(cfg_mode, wr_idx)));
        if (wr_idx < 3) wr_cap[wr_idx] = sys_data_in;
        if (wr_idx == 0) wr_first = cyc;
        wr_last = cyc;
        mem[sys_addr[3:0]] = sys_data_in;
        wr_idx++;
      end
      if (sys_cmd == 2'b10 && !sys_busy) begin
        check_eq("rd_addr", 48'(sys_addr), 48'(rd_idx));
        rd_idx++;
        if (int'(sys_addr) != cfg_drop) begin
          rd_cnt = L;
          rd_addr = int'(sys_addr[3:0]);
        end
      end
      prev_cmd_bus = {sys_cmd, sys_addr, sys_data_in};
      prev_busy = sys_busy;
    end
    @(posedge sys_clk);
    #1;
    sys_busy = (int'($urandom_range(99)) < cfg_busy_pct);
    sys_data_valid = 1'b0;
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        sys_data_valid = 1'b1;
        sys_data_out = mem[rd_addr];
        if (rd_addr == cfg_stuck) sys_data_out[3] = 1'b0;
      end
    end
  end

  task automatic pulse_start(input int mode);
    @(posedge sys_clk); #1;
    pattern_sel = 2'(mode);
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
  endtask

  task automatic check_reset_vals(input string name);
    check_eq({name, ":cmd"}, 48'(sys_cmd), 48'(0));
    check_eq({name, ":addr"}, 48'(sys_addr), 48'(0));
    check_eq({name, ":din"}, 48'(sys_data_in), 48'(0));
    check_eq({name, ":flags"}, 48'({running, done, fail}), 48'(0));
    check_eq({name, ":err"}, 48'(err_count), 48'(0));
    check_eq({name, ":first"}, 48'(first_err_addr), 48'(0));
  endtask

  // One full run; expected results computed from the fault configuration.
  task automatic run_pass(input string name, input int mode, input int busy,
                          input int stuck, input int drop);
    int n, e, first;
    logic [15:0] pv;
    cfg_mode = mode; cfg_busy_pct = busy; cfg_stuck = stuck; cfg_drop = drop;
    pulse_start(mode);
    check_eq({name, ":run_dn"}, 48'({running, done}), 48'(2'b10));
    n = 0;
    while (!done && n < 3000) begin @(negedge sys_clk); n++; end
    check_eq({name, ":done"}, 48'({running, done}), 48'(2'b01));
    e = 0; first = 0;
    for (int a = 0; a < N; a++) begin
      pv = ref_pat(mode, a);
      if (a == drop || (a == stuck && pv[3])) begin
        if (e == 0) first = a;
        e++;
      end
    end
    check_eq({name, ":fail"}, 48'(fail), 48'(e != 0));
    check_eq({name, ":err"}, 48'(err_count), 48'(e));
    check_eq({name, ":first"}, 48'(first_err_addr), 48'(first));
    check_eq({name, ":nwr"}, 48'(wr_idx), 48'(N));
    check_eq({name, ":nrd"}, 48'(rd_idx), 48'(N));
    if (busy == 0) check_eq({name, ":wr_span"}, 48'(wr_last - wr_first), 48'(N - 1));
  endtask

  initial begin
    int n;
    repeat (3) @(posedge sys_clk);
    #1;
    check_reset_vals("reset");
    sys_reset = 1'b0;

    run_pass("clean", 0, 0, -1, -1);
    run_pass("stuck", 1, 0, 5, -1);
    // start from DONE: done must drop on the very next cycle
    run_pass("bp", 2, 50, -1, -1);
    run_pass("lfsr", 3, 0, -1, -1);
    check_eq("lfsr_w0", 48'(wr_cap[0]), 48'(16'hACE1));
    check_eq("lfsr_w1", 48'(wr_cap[1]), 48'(16'h59C3));
    check_eq("lfsr_w2", 48'(wr_cap[2]), 48'(16'hB387));
    run_pass("timeout", 2, 0, -1, 7);

    for (int i = 0; i < 4; i++)
      run_pass($sformatf("rand%0d", i), int'($urandom_range(3)), 50,
               int'($urandom_range(15)), -1);

    // Reset during the read pass.
    cfg_mode = 2; cfg_busy_pct = 0; cfg_stuck = -1; cfg_drop = -1;
    pulse_start(2);
    n = 0;
    while (rd_idx < 4 && n < 1000) begin @(negedge sys_clk); n++; end
    check_eq("mid_reached_rd", 48'(rd_idx >= 4), 48'(1));
    @(posedge sys_clk); #1;
    sys_reset = 1'b1;
    #1;
    check_reset_vals("mid_reset");
    repeat (2) @(posedge sys_clk);
    #1;
    sys_reset = 1'b0;
    run_pass("after_reset", 0, 0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sdram_test_master.md
# sdram_test_master

Self-checking traffic generator that drives the host side of the SDRAM controller (`sys_addr` / `sys_cmd` / `sys_data_in` in, `sys_data_out` back). It sits between the board-level start/status logic and the controller.

- Write pass: writes a deterministic pattern to every address `0..LAST_ADDR`.
- Read pass: reads every location back, compares against the regenerated pattern, and reports the error count and the first failing address.

## Interface
Parameters:
- `LAST_ADDR`, 23'h7FFFFF: highest word address exercised; both passes cover `0..LAST_ADDR` inclusive.
- `TIMEOUT`, 255: maximum `sys_clk` cycles allowed from read acceptance to `sys_data_valid`.
- `LFSR_SEED`, 16'hACE1: seed for pattern mode 3; must be non-zero.

Ports:
- `sys_clk`  in  1: single clock. All logic is rising-edge.
- `sys_reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: one-cycle pulse. Honoured only in IDLE or DONE.
- `pattern_sel`  in  2: pattern mode. Sampled on `start`.
- `sys_addr`  out  23: word address to the controller.
- `sys_cmd`  out  2: 00 NOP, 01 WRITE, 10 READ; 11 is never driven.
- `sys_data_in`  out  16: write data to the controller.
- `sys_busy`  in  1: controller cannot accept a command this cycle.
- `sys_data_out`  in  16: read data from the controller.
- `sys_data_valid`  in  1: one-cycle strobe qualifying `sys_data_out`.
- `running`  out  1: high from the `start` acceptance until DONE.
- `done`  out  1: high in DONE.
- `fail`  out  1: high in DONE if any mismatch or timeout occurred.
- `err_count`  out  16: mismatch count plus timeout count, saturating at 16'hFFFF.
- `first_err_addr`  out  23: address of the first error in the current run.

## Operation
- Reset values:
  - state IDLE
  - `sys_cmd`=00, `sys_addr`=0, `sys_data_in`=0
  - `running`=0, `done`=0, `fail`=0
  - `err_count`=0, `first_err_addr`=0
  - LFSR = `LFSR_SEED`
- Pattern p(a) for address a, selected by `pattern_sel` latched on `start`:
  - 0: a[15:0]
  - 1: ~a[15:0]
  - 2: a[15:0] ^ {a[22:16], 9'h000}
  - 3: the LFSR value. Polynomial x^16+x^14+x^13+x^11+1, Fibonacci form, shift-left; new bit0 = q[15]^q[13]^q[12]^q[10].
- LFSR stepping (mode 3):
  - Loaded with the seed on `start` and again on the WR_ISSUE→RD_ISSUE transition.
  - Advances once per accepted write and once per compared read, so read-pass values equal write-pass values per address.
- States:
  - IDLE: outputs quiescent. `start` → WR_ISSUE; address counter=0; `err_count`=0; `first_err_addr`=0; `fail`=0.
  - WR_ISSUE:
    - Drives `sys_cmd`=01, `sys_addr`=counter, `sys_data_in`=p(counter).
    - A command is accepted in any cycle where `sys_cmd`≠00 and `sys_busy`=0.
    - On acceptance: if counter=`LAST_ADDR`, counter=0 → RD_ISSUE; else counter+1 and stay.
  - RD_ISSUE:
    - Drives `sys_cmd`=10, `sys_addr`=counter.
    - On acceptance → RD_WAIT; `sys_cmd`=00 from the next cycle; timeout counter=0.
  - RD_WAIT: exactly one read is outstanding.
    - On `sys_data_valid`: compare `sys_data_out` with p(counter).
      - On mismatch, increment `err_count` (saturating).
      - If this is the first error of the run, `first_err_addr`=counter.
    - On timeout counter reaching `TIMEOUT` without valid: record as one error, same way.
    - After either outcome: if counter=`LAST_ADDR` → DONE; else counter+1 → RD_ISSUE.
  - DONE:
    - `done`=1; `fail`=(`err_count`≠0).
    - `start` → same as from IDLE; `done` clears in the next cycle.
- Ignored inputs:
  - `sys_data_valid` outside RD_WAIT is ignored; it is not counted.
  - `start` in WR_ISSUE, RD_ISSUE or RD_WAIT is ignored.
- `sys_reset` mid-run: immediate return to reset values. No command is held; `sys_cmd`=00 asynchronously.

## Timing
- `sys_cmd`, `sys_addr` and `sys_data_in` are registered.
- Command hold: a command stays stable while `sys_busy`=1. It changes only in the cycle after acceptance.
- Back-to-back writes with `sys_busy`=0: one write per cycle. `LAST_ADDR`+1 writes occupy `LAST_ADDR`+1 consecutive cycles.
- Read loop per address: 1 issue cycle, plus controller latency L, plus 1 compare cycle before the next READ is driven.
- Error accounting: `err_count` and `first_err_addr` update in the cycle after the `sys_data_valid` strobe.
- `done` is asserted in the cycle after the last compare.
- `running` and `done` are never both high.
- Timeout fires in the cycle where the wait count equals `TIMEOUT`. Valid arriving in that same cycle takes priority and is compared normally.

## Test plan
- Clean run:
  - Setup: `LAST_ADDR`=15, mode 0, ideal memory model with L=3, `sys_busy`=0.
  - Required: 16 writes in 16 consecutive cycles with data 0..15; then 16 reads; `done`=1, `fail`=0, `err_count`=0.
- Stuck bit:
  - Setup: mode 1, model forces bit 3 of address 5's data to 0.
  - Required: `fail`=1, `err_count`=1, `first_err_addr`=5.
- Backpressure:
  - Setup: `sys_busy` randomly high 50% of cycles.
  - Required: every command is held stable until accepted; no address is skipped or duplicated; `fail`=0.
- LFSR mode:
  - Setup: mode 3.
  - Required: the first three write data are 16'hACE1, 16'h59C3, 16'hB387; the read pass passes against the same memory.
- Timeout:
  - Setup: model drops the read response for address 7, `TIMEOUT`=8.
  - Required: `err_count`=1, `first_err_addr`=7, the run continues to DONE.
- Reset mid-run:
  - Setup: assert `sys_reset` during the read pass.
  - Required: `sys_cmd`=00 and all outputs at reset values immediately; a subsequent `start` gives a clean pass.
